// File: rtl/matmul_dot_sequencer.sv
// Streams C = A*B for 8x8 signed matrices held in async-read RAMs, one dot product per cycle.
// Optional build macro MATMUL_B_TRANSPOSED_EN: B RAM holds B^T, so B lanes read row j of B^T.
module matmul_dot_sequencer #(
  parameter int N  = 8,
  parameter int DW = 8,
  parameter int AW = 6,
  parameter int CW = 19
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [N*AW-1:0]     a_addr,
  input  logic [N*DW-1:0]     a_val,
  output logic [N*AW-1:0]     b_addr,
  input  logic [N*DW-1:0]     b_val,
  output logic                c_valid,
  input  logic                c_ready,
  output logic [2:0]          c_row,
  output logic [2:0]          c_col,
  output logic [CW-1:0]       c_data
);

  localparam int PW = 2 * DW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state;
  logic [2:0]            i, j, ni, nj;
  logic                  stall, last;
  logic                  s1_valid;
  logic [2:0]            s1_i, s1_j;
  logic signed [PW-1:0]  s1_prod [N];
  logic signed [CW-1:0]  dot;

  assign stall = c_valid && !c_ready;
  assign last  = (i == 3'(N - 1)) && (j == 3'(N - 1));

  always_comb begin
    nj = j + 3'd1;
    ni = i;
    if (j == 3'(N - 1)) begin
      nj = '0;
      ni = i + 3'd1;
    end
  end

  function automatic logic [N*AW-1:0] a_lanes(input logic [2:0] r);
    logic [N*AW-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < N; k++)
      v[k*AW +: AW] = AW'(r) * AW'(N) + AW'(k);
    return v;
  endfunction

  function automatic logic [N*AW-1:0] b_lanes(input logic [2:0] c);
    logic [N*AW-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < N; k++)
`ifdef MATMUL_B_TRANSPOSED_EN
      v[k*AW +: AW] = AW'(c) * AW'(N) + AW'(k);
`else
      v[k*AW +: AW] = AW'(k) * AW'(N) + AW'(c);
`endif
    return v;
  endfunction

  // i/j name the element whose addresses are on the bus this cycle; the first
  // element is loaded on the start edge so RUN presents one element per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      i      <= '0;
      j      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      a_addr <= '0;
      b_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state  <= RUN;
          busy   <= 1'b1;
          i      <= '0;
          j      <= '0;
          a_addr <= a_lanes('0);
          b_addr <= b_lanes('0);
        end
        RUN: if (!stall) begin
          if (last) begin
            state <= DRAIN;
          end else begin
            i      <= ni;
            j      <= nj;
            a_addr <= a_lanes(ni);
            b_addr <= b_lanes(nj);
          end
        end
        DRAIN: if (c_valid && c_ready && c_row == 3'(N - 1) && c_col == 3'(N - 1)) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dot = '0;
    for (int unsigned k = 0; k < N; k++)
      dot = dot + CW'(s1_prod[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_i     <= '0;
      s1_j     <= '0;
      for (int unsigned k = 0; k < N; k++)
        s1_prod[k] <= '0;
      c_valid  <= 1'b0;
      c_row    <= '0;
      c_col    <= '0;
      c_data   <= '0;
    end else if (!stall) begin
      s1_valid <= (state == RUN);
      s1_i     <= i;
      s1_j     <= j;
      for (int unsigned k = 0; k < N; k++)
        s1_prod[k] <= PW'($signed(a_val[k*DW +: DW])) * PW'($signed(b_val[k*DW +: DW]));
      c_valid  <= s1_valid;
      if (s1_valid) begin
        c_data <= dot;
        c_row  <= s1_i;
        c_col  <= s1_j;
      end
    end
  end

endmodule

// File: tb/tb_matmul_dot_sequencer.sv
// Scoreboard bench for matmul_dot_sequencer: RAM models, matrix reference model, ready-stall and reset scenarios.
module tb_matmul_dot_sequencer;
  localparam int N = 8, DW = 8, AW = 6, CW = 19;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, c_ready = 1'b1;
  logic busy, done, c_valid;
  logic [N*AW-1:0] a_addr, b_addr;
  logic [N*DW-1:0] a_val, b_val;
  logic [2:0] c_row, c_col;
  logic [CW-1:0] c_data;

  logic [7:0] mem_a [64];
  logic [7:0] mem_b [64];
  int ma [8][8];
  int mb [8][8];

  typedef struct { int r; int c; int v; } exp_t;
  exp_t sb [$];

  int checks = 0, errors = 0, done_cnt = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_ram
    assign a_val[k*DW +: DW] = mem_a[a_addr[k*AW +: AW]];
    assign b_val[k*DW +: DW] = mem_b[b_addr[k*AW +: AW]];
  end

  matmul_dot_sequencer #(.N(N), .DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .a_addr(a_addr), .a_val(a_val), .b_addr(b_addr), .b_val(b_val),
    .c_valid(c_valid), .c_ready(c_ready), .c_row(c_row), .c_col(c_col), .c_data(c_data)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // kind: 0 ones*I, 1 -128*-128, 2 -128*127, 3 (i+k)*I, 4 random
  task automatic set_mats(input int kind);
    int acc;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        case (kind)
          0: begin ma[r][c] = 1; mb[r][c] = (r == c) ? 1 : 0; end
          1: begin ma[r][c] = -128; mb[r][c] = -128; end
          2: begin ma[r][c] = -128; mb[r][c] = 127; end
          3: begin ma[r][c] = r + c; mb[r][c] = (r == c) ? 1 : 0; end
          default: begin
            ma[r][c] = int'($urandom_range(255)) - 128;
            mb[r][c] = int'($urandom_range(255)) - 128;
          end
        endcase
      end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        mem_a[r*8+c] = 8'(ma[r][c]);
`ifdef MATMUL_B_TRANSPOSED_EN
        mem_b[c*8+r] = 8'(mb[r][c]);
`else
        mem_b[r*8+c] = 8'(mb[r][c]);
`endif
      end
    sb.delete();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        acc = 0;
        for (int k = 0; k < 8; k++) acc += ma[r][k] * mb[k][c];
        sb.push_back('{r: r, c: c, v: acc});
      end
  endtask

  // Monitor: pops on every handshake and checks held outputs during stalls.
  initial begin
    exp_t e;
    logic stall_prev;
    logic [25:0] held;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev)
          check("stall_hold", int'({c_valid, c_row, c_col, c_data}), int'(held));
        if (done) done_cnt++;
        if (c_valid && c_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_result", int'({c_row, c_col}), -1);
          end else begin
            e = sb.pop_front();
            check("row_col", int'({c_row, c_col}), e.r * 8 + e.c);
            check("c_data", int'($signed(c_data)), e.v);
          end
        end
        stall_prev = c_valid && !c_ready;
        held = {1'b1, c_row, c_col, c_data};
      end
    end
  end

  // mode: 0 ready=1, 1 random ready, 2 stall 5 cycles on (0,3), 3 extra start at cycle 10, 4 reset on (2,5)
  task automatic run(input int mode, output int cycles);
    int stalls, base;
    bit fin;
    stalls = 0;
    fin = 0;
    base = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    cycles = 1;
    while (!fin && cycles < 3000) begin
      if (done && mode != 4) begin
        fin = 1;
      end else begin
        c_ready = 1'b1;
        start = 1'b0;
        case (mode)
          1: c_ready = ($urandom_range(3) != 0);
          2: if (c_valid && c_row == 3'd0 && c_col == 3'd3 && stalls < 5) begin
               c_ready = 1'b0;
               stalls++;
             end
          3: start = (cycles == 10);
          4: if (c_valid && c_row == 3'd2 && c_col == 3'd5) begin
               rst = 1'b1;
               c_ready = 1'b0;
               fin = 1;
             end
          default: ;
        endcase
        @(posedge clk); #1;
        cycles++;
      end
    end
    start = 1'b0;
    c_ready = 1'b1;
    if (!fin) check("run_timeout", cycles, -1);
    if (mode == 4) begin
      check("rst_busy", int'(busy), 0);
      check("rst_c_valid", int'(c_valid), 0);
      rst = 1'b0;
      sb.delete();
      check("rst_no_done", done_cnt - base, 0);
    end else begin
      @(negedge clk); #1;
      check("done_count", done_cnt - base, 1);
      check("results_left", sb.size(), 0);
      @(posedge clk); #1;
      check("busy_after_done", int'(busy), 0);
    end
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_c_valid", int'(c_valid), 0);
    check("reset_row_col", int'({c_row, c_col}), 0);
    check("reset_c_data", int'(c_data), 0);
    check("reset_addr_nonzero", int'(a_addr != '0) + int'(b_addr != '0), 0);
    rst = 1'b0;

    set_mats(0); run(0, cyc); check("cycles_full_rate", cyc, 67);
    set_mats(1); run(1, cyc);
    set_mats(2); run(0, cyc); check("cycles_neg_pos", cyc, 67);
    set_mats(3); run(2, cyc); check("cycles_stalled", cyc, 72);
    set_mats(4); run(4, cyc);
    set_mats(3); run(0, cyc); check("cycles_after_reset", cyc, 67);
    set_mats(4); run(3, cyc); check("cycles_restart_ignored", cyc, 67);
    for (int n = 0; n < 3; n++) begin
      set_mats(4);
      run(1, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
